// File: rtl/adder_pkg.sv
// adder_pkg: shared widths, word type and carry-lookahead helpers
// for the registered datapath adder.
package adder_pkg;

  localparam int DATA_W  = 32;
  localparam int SLICE_W = 16;
  localparam int GRP_W   = 4;
  localparam int NGRP    = SLICE_W / GRP_W;

  typedef logic [DATA_W-1:0] word_t;

  // Group generate of a 4-bit lookahead block.
  function automatic logic cla4_g(
    input logic [GRP_W-1:0] g,
    input logic [GRP_W-1:0] p
  );
    return g[3]
         | (p[3] & g[2])
         | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]);
  endfunction

  // Group propagate of a 4-bit lookahead block.
  function automatic logic cla4_p(
    input logic [GRP_W-1:0] p
  );
    return &p;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// adder_slice: 16-bit carry-lookahead adder, four 4-bit groups.
// a, b, cin in; sum, cout and cmsb (carry into bit 15) out.
module adder_slice
  import adder_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout,
  output logic               cmsb
);

  logic [SLICE_W-1:0] g;
  logic [SLICE_W-1:0] p;
  logic [SLICE_W-1:0] c;
  logic [NGRP-1:0]    gg;
  logic [NGRP-1:0]    gp;
  logic [NGRP-1:0]    gc;

  assign g = a & b;
  assign p = a ^ b;

  for (genvar k = 0; k < NGRP; k++) begin : g_grp
    localparam int L = GRP_W * k;

    assign gg[k] = cla4_g(g[L+3:L], p[L+3:L]);
    assign gp[k] = cla4_p(p[L+3:L]);

    assign c[L]   = gc[k];
    assign c[L+1] = g[L]
                  | (p[L] & gc[k]);
    assign c[L+2] = g[L+1]
                  | (p[L+1] & g[L])
                  | (p[L+1] & p[L] & gc[k]);
    assign c[L+3] = g[L+2]
                  | (p[L+2] & g[L+1])
                  | (p[L+2] & p[L+1] & g[L])
                  | (p[L+2] & p[L+1] & p[L]
                     & gc[k]);
  end

  // Second-level lookahead across the four groups.
  assign gc[0] = cin;
  assign gc[1] = gg[0]
               | (gp[0] & cin);
  assign gc[2] = gg[1]
               | (gp[1] & gg[0])
               | (gp[1] & gp[0] & cin);
  assign gc[3] = gg[2]
               | (gp[2] & gg[1])
               | (gp[2] & gp[1] & gg[0])
               | (&gp[2:0] & cin);
  assign cout  = gg[3]
               | (gp[3] & gg[2])
               | (gp[3] & gp[2] & gg[1])
               | (&gp[3:1] & gg[0])
               | (&gp & cin);

  assign sum  = p ^ c;
  assign cmsb = c[SLICE_W-1];

endmodule

// File: rtl/adder32.sv
// adder32: registered WIDTH-bit adder with carry, signed-overflow
// and zero flags; one-cycle latency, async active-high reset.
module adder32
  import adder_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NS = WIDTH / SLICE_W;

  if (WIDTH % SLICE_W != 0 || WIDTH == 0) begin : g_bad_w
    $error("adder32: WIDTH must be a multiple of 16");
  end

  logic [WIDTH-1:0] s;
  logic [NS:0]      cc;
  logic [NS-1:0]    msbc;
  logic             cout_n;
  logic             ovf_n;
  logic             zero_n;

  assign cc[0] = 1'b0;

  for (genvar i = 0; i < NS; i++) begin : g_sl
    localparam int LO = SLICE_W * i;
    localparam int HI = LO + SLICE_W - 1;

    adder_slice u_sl (
      .a    (A[HI:LO]),
      .b    (B[HI:LO]),
      .cin  (cc[i]),
      .sum  (s[HI:LO]),
      .cout (cc[i+1]),
      .cmsb (msbc[i])
    );

    // The carry into a slice's top bit is recoverable from its
    // operand and sum bits; a disagreement means a broken chain.
    a_msbc : assert property (
      @(posedge clk) disable iff (rst)
      msbc[i] == (s[HI] ^ A[HI] ^ B[HI])
    );
  end

  // Signed overflow: carry into the MSB differs from carry out.
  assign cout_n = cc[NS];
  assign ovf_n  = msbc[NS-1] ^ cc[NS];
  assign zero_n = ~|s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      C    <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
      zero <= 1'b1;
    end else begin
      C    <= s;
      cout <= cout_n;
      ovf  <= ovf_n;
      zero <= zero_n;
    end
  end

endmodule

// File: tb/tb_adder32.sv
// tb_adder32: directed vector table plus reset and random-stream
// sequences for the registered adder.
module tb_adder32;
  import adder_pkg::*;

  typedef struct {
    word_t a;
    word_t b;
    word_t c;
    logic  co;
    logic  ov;
    logic  z;
  } vec_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  word_t a   = '0;
  word_t b   = '0;
  word_t c;
  logic  cout;
  logic  ovf;
  logic  zero;

  int total  = 0;
  int passed = 0;

  adder32 #(.WIDTH(DATA_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .A    (a),
    .B    (b),
    .C    (c),
    .cout (cout),
    .ovf  (ovf),
    .zero (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string name,
    input word_t ec,
    input logic  eco,
    input logic  eov,
    input logic  ez
  );
    total++;
    if (c === ec && cout === eco && ovf === eov && zero === ez) begin
      passed++;
    end else begin
      $display("FAIL %s: got C=%h cout=%b ovf=%b zero=%b, need C=%h cout=%b ovf=%b zero=%b",
               name, c, cout, ovf, zero, ec, eco, eov, ez);
    end
  endtask

  // Independent model: wide unsigned sum and signed range test.
  task automatic chk_model(input string name, input word_t x, input word_t y);
    longint unsigned us;
    longint          ss;
    word_t           ec;
    logic            eov;
    us  = longint'(x) + longint'(y);
    ss  = longint'($signed(x)) + longint'($signed(y));
    ec  = us[DATA_W-1:0];
    eov = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
    chk(name, ec, us[DATA_W], eov, ec == '0);
  endtask

  vec_t vt[$];

  initial begin
    vt.push_back('{32'h8000001F, 32'h80000001, 32'h00000020, 1, 1, 0});
    vt.push_back('{32'h80000002, 32'h80000001, 32'h00000003, 1, 1, 0});
    vt.push_back('{32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 0, 1});
    vt.push_back('{32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 1, 0});
    vt.push_back('{32'h0000FFFF, 32'h00000001, 32'h00010000, 0, 0, 0});
    vt.push_back('{32'h80000000, 32'h80000000, 32'h00000000, 1, 1, 1});
    vt.push_back('{32'h00000000, 32'h00000000, 32'h00000000, 0, 0, 1});
    vt.push_back('{32'h12345678, 32'h9ABCDEF0, 32'hACF13568, 0, 0, 0});
    vt.push_back('{32'hFFFF0000, 32'h0000FFFF, 32'hFFFFFFFF, 0, 0, 0});
    vt.push_back('{32'h00000FFF, 32'h00000001, 32'h00001000, 0, 0, 0});
    vt.push_back('{32'h7FFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFE, 0, 1, 0});
    vt.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1, 0, 0});
    vt.push_back('{32'h0001FFFF, 32'h0000FFFF, 32'h0002FFFE, 0, 0, 0});

    repeat (2) @(posedge clk);
    #1 chk("reset_initial", 32'h0, 0, 0, 1);

    @(negedge clk);
    rst = 1'b0;
    a   = 32'h00000001;
    b   = 32'h00000002;
    @(posedge clk);
    #1 chk("pre_reset_sum", 32'h00000003, 0, 0, 0);

    #2 rst = 1'b1;
    #1 chk("async_reset", 32'h0, 0, 0, 1);
    rst = 1'b0;
    #1 chk("release_hold", 32'h0, 0, 0, 1);

    foreach (vt[i]) begin
      @(negedge clk);
      a = vt[i].a;
      b = vt[i].b;
      @(posedge clk);
      #1 chk($sformatf("vec%0d", i), vt[i].c, vt[i].co, vt[i].ov, vt[i].z);
    end

    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      a = $urandom;
      b = $urandom;
      if (i == 5) b = ~a;
      if (i == 6) b = -a;
      @(posedge clk);
      #1 chk_model($sformatf("stream%0d", i), a, b);
      if (i == 20) begin
        #1 rst = 1'b1;
        #1 chk("mid_reset", 32'h0, 0, 0, 1);
        @(posedge clk);
        #1 chk("mid_reset_hold", 32'h0, 0, 0, 1);
        @(negedge clk);
        rst = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
